// File: rtl/mul_div_pkg.sv
// Shared types and helpers for the HI/LO multiply/divide sequencer.
package mul_div_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_MUL   = 4'd3,
    MD_MADD  = 4'd4,
    MD_MADDU = 4'd5,
    MD_MSUB  = 4'd6,
    MD_MSUBU = 4'd7,
    MD_DIV   = 4'd8,
    MD_DIVU  = 4'd9,
    MD_MTHI  = 4'd10,
    MD_MTLO  = 4'd11
  } md_op;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_ITER = 2'd2,
    DIV_FIX  = 2'd3
  } md_state;

  localparam int DIV_ITERS = 32;

  // Any operation that goes through the registered multiplier.
  function automatic logic is_mul_op(input md_op o);
    return (o == MD_MULT) || (o == MD_MULTU) || (o == MD_MUL) ||
           (o == MD_MADD) || (o == MD_MADDU) ||
           (o == MD_MSUB) || (o == MD_MSUBU);
  endfunction

  // Operations whose operands are treated as two's complement.
  function automatic logic is_signed_op(input md_op o);
    return (o == MD_MULT) || (o == MD_MUL) || (o == MD_MADD) ||
           (o == MD_MSUB) || (o == MD_DIV);
  endfunction

  // 32-bit two's-complement negation (wraps for 0x80000000).
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/div_radix2_core.sv
// Radix-2 restoring divider datapath: one quotient bit per step.
// Operands are unsigned magnitudes; sign handling lives in the sequencer.
module div_radix2_core (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic [32:0] shifted;
  logic [33:0] trial;
  logic        fits;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    trial   = {1'b0, shifted} - {2'b00, dvs_q};
    fits    = ~trial[33];
  end

  // Partial remainder / quotient shift registers; the quotient register
  // starts out holding the dividend and fills with quotient bits from the LSB.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (step) begin
      rem_q <= fits ? trial[31:0] : shifted[31:0];
      quo_q <= {quo_q[30:0], fits};
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mul_div_sequencer.sv
// HI/LO multiply/divide sequencer for the execute stage. Runs one
// multiply, accumulate, divide or HI/LO move at a time and stalls via busy.
module mul_div_sequencer
  import mul_div_pkg::*;
#(
  parameter int MUL_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  md_op        op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mul_div_lo
);

  localparam logic [4:0] MUL_LOAD = 5'(MUL_LATENCY - 1);
  localparam logic [4:0] DIV_LOAD = 5'(DIV_ITERS - 1);

  md_state     state, state_next;
  logic [4:0]  cnt;
  md_op        op_q;
  logic [63:0] prod_q;
  logic        sgn_dvd, sgn_dvs;

  logic        accept_mt, accept_mul, accept_div;
  logic        commit_mul, commit_div, div_step;

  logic        op_signed;
  logic [63:0] ext_rs, ext_rt, product;
  logic        dvd_neg, dvs_neg;
  logic [31:0] dvd_mag, dvs_mag;
  logic [31:0] quotient, remainder;
  logic [31:0] quo_fix, rem_fix;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state and control strobes; flush always wins and suppresses commit.
  always_comb begin
    state_next = state;
    accept_mt  = 1'b0;
    accept_mul = 1'b0;
    accept_div = 1'b0;
    commit_mul = 1'b0;
    commit_div = 1'b0;
    div_step   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          if (op == MD_MTHI || op == MD_MTLO) begin
            accept_mt = 1'b1;
          end else if (is_mul_op(op)) begin
            accept_mul = 1'b1;
            state_next = MUL_WAIT;
          end else if (op == MD_DIV || op == MD_DIVU) begin
            accept_div = 1'b1;
            state_next = DIV_ITER;
          end
        end
      end
      MUL_WAIT: begin
        if (flush) begin
          state_next = IDLE;
        end else if (cnt == 5'd0) begin
          commit_mul = 1'b1;
          state_next = IDLE;
        end
      end
      DIV_ITER: begin
        if (flush) begin
          state_next = IDLE;
        end else begin
          div_step = 1'b1;
          if (cnt == 5'd0) state_next = DIV_FIX;
        end
      end
      DIV_FIX: begin
        state_next = IDLE;
        if (!flush) commit_div = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand preparation: sign/zero extension for the multiplier and
  // magnitudes for the divider.
  always_comb begin
    op_signed = is_signed_op(op);
    ext_rs    = op_signed ? {{32{rs[31]}}, rs} : {32'd0, rs};
    ext_rt    = op_signed ? {{32{rt[31]}}, rt} : {32'd0, rt};
    product   = ext_rs * ext_rt;
    dvd_neg   = (op == MD_DIV) && rs[31];
    dvs_neg   = (op == MD_DIV) && rt[31];
    dvd_mag   = dvd_neg ? neg32(rs) : rs;
    dvs_mag   = dvs_neg ? neg32(rt) : rt;
  end

  div_radix2_core u_div (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (accept_div),
    .step      (div_step),
    .dividend  (dvd_mag),
    .divisor   (dvs_mag),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // Quotient takes the XOR of the signs; remainder follows the dividend.
  always_comb begin
    quo_fix = (sgn_dvd ^ sgn_dvs) ? neg32(quotient) : quotient;
    rem_fix = sgn_dvd ? neg32(remainder) : remainder;
  end

  // Sequencing counter, latched operation context and the done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      op_q    <= MD_NONE;
      prod_q  <= '0;
      sgn_dvd <= 1'b0;
      sgn_dvs <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= accept_mt | commit_mul | commit_div;
      if (accept_mul) begin
        cnt    <= MUL_LOAD;
        op_q   <= op;
        prod_q <= product;
      end else if (accept_div) begin
        cnt     <= DIV_LOAD;
        op_q    <= op;
        sgn_dvd <= dvd_neg;
        sgn_dvs <= dvs_neg;
      end else if ((state == MUL_WAIT || state == DIV_ITER) && cnt != 5'd0) begin
        cnt <= cnt - 5'd1;
      end
    end
  end

  // Architectural HI/LO and the MUL result word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi         <= '0;
      lo         <= '0;
      mul_div_lo <= '0;
    end else if (accept_mt) begin
      if (op == MD_MTHI) hi <= rs;
      else               lo <= rs;
    end else if (commit_mul) begin
      case (op_q)
        MD_MULT, MD_MULTU: {hi, lo} <= prod_q;
        MD_MADD, MD_MADDU: {hi, lo} <= {hi, lo} + prod_q;
        MD_MSUB, MD_MSUBU: {hi, lo} <= {hi, lo} - prod_q;
        MD_MUL:            mul_div_lo <= prod_q[31:0];
        default: ;
      endcase
    end else if (commit_div) begin
      lo <= quo_fix;
      hi <= rem_fix;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Directed bench for mul_div_sequencer with a cycle-level expectation model.
module tb_mul_div_sequencer;
  import mul_div_pkg::*;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  md_op        op = MD_NONE;
  logic [31:0] rs = '0;
  logic [31:0] rt = '0;
  logic        busy, done;
  logic [31:0] hi, lo, mul_div_lo;

  int total = 0;
  int bad = 0;

  logic        exp_busy = 1'b0;
  logic        exp_done = 1'b0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  logic [31:0] exp_mdlo = '0;
  bit          checking = 1'b0;

  mul_div_sequencer #(.MUL_LATENCY(L)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .op         (op),
    .rs         (rs),
    .rt         (rt),
    .flush      (flush),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo),
    .mul_div_lo (mul_div_lo)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at t=%0t: actual=%h required=%h", name, $time, act, req);
    end
  endtask

  // Every cycle, away from the active edge, the DUT must match the model.
  always @(negedge clk) begin
    if (checking) begin
      check32("busy", {31'd0, busy}, {31'd0, exp_busy});
      check32("done", {31'd0, done}, {31'd0, exp_done});
      check32("hi", hi, exp_hi);
      check32("lo", lo, exp_lo);
      check32("mul_div_lo", mul_div_lo, exp_mdlo);
    end
  end

  // New {HI,LO} that an operation must leave behind, from the arithmetic rules.
  function automatic logic [63:0] model_hilo(input md_op o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] hl);
    logic [63:0] sa, sb, ua, ub;
    longint      da, db, dq, dr;
    logic [31:0] q32, r32;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      MD_MULT:  return sa * sb;
      MD_MULTU: return ua * ub;
      MD_MADD:  return hl + sa * sb;
      MD_MADDU: return hl + ua * ub;
      MD_MSUB:  return hl - sa * sb;
      MD_MSUBU: return hl - ua * ub;
      MD_MTHI:  return {a, hl[31:0]};
      MD_MTLO:  return {hl[63:32], a};
      MD_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q32 = a / b;
        r32 = a % b;
        return {r32, q32};
      end
      MD_DIV: begin
        if (b == 32'd0) begin
          q32 = 32'hFFFF_FFFF;
          r32 = a[31] ? -a : a;
          if (a[31] != b[31]) q32 = -q32;
          if (a[31]) r32 = -r32;
        end else begin
          da = sa;
          db = sb;
          dq = da / db;
          dr = da % db;
          q32 = dq[31:0];
          r32 = dr[31:0];
        end
        return {r32, q32};
      end
      default:  return hl;
    endcase
  endfunction

  function automatic int latency(input md_op o);
    if (o == MD_DIV || o == MD_DIVU) return DIV_ITERS + 1;
    if (o == MD_MTHI || o == MD_MTLO || o == MD_NONE) return 0;
    return L;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    exp_done = 1'b0;
  endtask

  // Issue one operation; flush_at selects a busy cycle (1-based) to flush in,
  // hold keeps start asserted for the whole busy period.
  task automatic run_op(input md_op o, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, input bit hold);
    logic [63:0] nh;
    logic [31:0] nm;
    logic [63:0] full;
    int          lat;
    nh   = model_hilo(o, a, b, {exp_hi, exp_lo});
    full = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    nm   = (o == MD_MUL) ? full[31:0] : exp_mdlo;
    lat  = latency(o);
    start = 1'b1;
    op = o;
    rs = a;
    rt = b;
    tick();
    if (!hold) start = 1'b0;
    if (lat == 0) begin
      {exp_hi, exp_lo} = nh;
      exp_done = 1'b1;
      return;
    end
    exp_busy = 1'b1;
    for (int c = 1; c <= lat; c++) begin
      if (c == flush_at) flush = 1'b1;
      tick();
      if (c == flush_at) begin
        flush = 1'b0;
        start = 1'b0;
        exp_busy = 1'b0;
        return;
      end
    end
    start = 1'b0;
    exp_busy = 1'b0;
    exp_done = 1'b1;
    {exp_hi, exp_lo} = nh;
    exp_mdlo = nm;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 reset_n = 1'b0;
    checking = 1'b1;
    #1;
    check32("reset_busy", {31'd0, busy}, 32'd0);
    check32("reset_hi", hi, 32'd0);
    check32("reset_lo", lo, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();

    // HI/LO moves
    run_op(MD_MTHI, 32'h1234_5678, 32'd0, -1, 1'b0);
    check32("mthi_hi", hi, 32'h1234_5678);
    check32("mthi_busy", {31'd0, busy}, 32'd0);
    run_op(MD_MTLO, 32'h9ABC_DEF0, 32'd0, -1, 1'b0);
    check32("mtlo_lo", lo, 32'h9ABC_DEF0);
    tick();

    // Multiplies
    run_op(MD_MULT, 32'hFFFF_FFFF, 32'd2, -1, 1'b0);
    check32("mult_hi", hi, 32'hFFFF_FFFF);
    check32("mult_lo", lo, 32'hFFFF_FFFE);
    tick();
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, -1, 1'b0);
    check32("multu_hi", hi, 32'h0000_0001);
    check32("multu_lo", lo, 32'hFFFF_FFFE);

    // Accumulate from 0:FFFFFFFF
    run_op(MD_MTHI, 32'd0, 32'd0, -1, 1'b0);
    run_op(MD_MTLO, 32'hFFFF_FFFF, 32'd0, -1, 1'b0);
    run_op(MD_MADDU, 32'd1, 32'd1, -1, 1'b0);
    check32("maddu_hi", hi, 32'd1);
    check32("maddu_lo", lo, 32'd0);
    run_op(MD_MSUB, 32'd1, 32'd2, -1, 1'b0);
    check32("msub_hi", hi, 32'd0);
    check32("msub_lo", lo, 32'hFFFF_FFFE);
    tick();

    // Divides
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, -1, 1'b0);
    check32("div_lo", lo, 32'hFFFF_FFFD);
    check32("div_hi", hi, 32'hFFFF_FFFF);
    run_op(MD_DIVU, 32'd100, 32'd0, -1, 1'b0);
    check32("divu0_lo", lo, 32'hFFFF_FFFF);
    check32("divu0_hi", hi, 32'd100);
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
    check32("divovf_lo", lo, 32'h8000_0000);
    check32("divovf_hi", hi, 32'd0);
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd0, -1, 1'b0);
    run_op(MD_DIV, 32'd7, 32'hFFFF_FFFE, -1, 1'b0);
    tick();

    // Flush mid-divide, then a multiply still works
    run_op(MD_DIVU, 32'd12345, 32'd7, 10, 1'b0);
    check32("flush_done", {31'd0, done}, 32'd0);
    check32("flush_busy", {31'd0, busy}, 32'd0);
    run_op(MD_MULTU, 32'd3, 32'd4, -1, 1'b0);
    check32("multu34_lo", lo, 32'd12);

    // Flush on the commit cycle
    run_op(MD_MULT, 32'd5, 32'd5, L, 1'b0);
    tick();
    check32("flush_commit_lo", lo, 32'd12);

    // Flush and start together; and start with MD_NONE
    start = 1'b1; flush = 1'b1; op = MD_MTHI; rs = 32'hDEAD_BEEF;
    tick();
    start = 1'b0; flush = 1'b0;
    tick();
    check32("flush_start_hi", hi, 32'd0);
    start = 1'b1; op = MD_NONE;
    tick();
    start = 1'b0;
    tick();

    // start held across a busy divide, then MUL issued in the done cycle
    run_op(MD_DIVU, 32'd1000, 32'd7, -1, 1'b1);
    run_op(MD_MUL, 32'd5, 32'd6, -1, 1'b0);
    check32("mul_mdlo", mul_div_lo, 32'd30);
    check32("mul_lo_kept", lo, 32'd142);
    check32("mul_hi_kept", hi, 32'd6);
    tick();

    run_op(MD_MADD, 32'hFFFF_FFFF, 32'd3, -1, 1'b0);
    check32("madd_lo", lo, 32'd139);
    run_op(MD_MSUBU, 32'hFFFF_FFFF, 32'd2, -1, 1'b0);
    run_op(MD_MUL, 32'hFFFF_FFFD, 32'd7, -1, 1'b0);
    check32("mul_neg_mdlo", mul_div_lo, 32'hFFFF_FFEB);

    // Asynchronous reset in the middle of a divide
    start = 1'b1; op = MD_DIVU; rs = 32'd50; rt = 32'd3;
    tick();
    start = 1'b0;
    exp_busy = 1'b1;
    repeat (5) tick();
    #2 reset_n = 1'b0;
    exp_busy = 1'b0; exp_done = 1'b0;
    exp_hi = '0; exp_lo = '0; exp_mdlo = '0;
    #1;
    check32("rst_mid_busy", {31'd0, busy}, 32'd0);
    check32("rst_mid_hi", hi, 32'd0);
    check32("rst_mid_lo", lo, 32'd0);
    check32("rst_mid_mdlo", mul_div_lo, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
    run_op(MD_MTLO, 32'd55, 32'd0, -1, 1'b0);
    tick();
    check32("post_rst_lo", lo, 32'd55);

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
